// File: rtl/dmem_pkg.sv
// Shared encodings for the memory-stage data responder.
`timescale 1ns/1ps
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic int index_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/data_mem_responder.sv
// Word-addressed data array behind a fixed multi-cycle latency; stalls the
// pipeline for the whole access and pulses done_o once per completed request.
`timescale 1ns/1ps
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o
);

  localparam int IW = index_w(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t          state, state_nxt;
  op_t             op_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            mis_q;
  logic [CW-1:0]   cnt;
  logic            req;
  logic            last_edge;

  logic [31:0]     mem [DEPTH_WORDS];

  // High address bits deliberately fold the array modulo DEPTH_WORDS.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:IW+2];

  assign req       = MemRead_i | MemWrite_i;
  assign last_edge = (state == ACCESS) && (cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    done_o     = 1'b0;
    misalign_o = 1'b0;
    unique case (state)
      IDLE: begin
        stall_o = req;
        if (req) state_nxt = ACCESS;
      end
      ACCESS: begin
        stall_o = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        // Always fall back to IDLE so the request still held on EX/MEM
        // during this cycle is not serviced a second time.
        done_o     = 1'b1;
        misalign_o = mis_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q    <= OP_RD;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        op_q    <= MemWrite_i ? OP_WR : OP_RD;
        idx_q   <= addr_i[2 +: IW];
        wdata_q <= wdata_i;
        mis_q   <= (addr_i[1:0] != 2'b00);
        cnt     <= CW'(LATENCY - 1);
      end
    end else if (state == ACCESS && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Array is not reset; a write only commits on the final ACCESS edge,
  // which cannot happen once reset has forced the FSM back to IDLE.
  always_ff @(posedge clk_i) begin
    if (last_edge && op_q == OP_WR) mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           rdata_o <= '0;
    else if (last_edge && op_q == OP_RD) rdata_o <= mem[idx_q];
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one LATENCY=3 instance for function/reset checks and one
// LATENCY=1 instance for back-to-back throughput.
`timescale 1ns/1ps
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        mr0, mw0, stall0, done0, mis0;
  logic [31:0] addr0, wd0, rdata0;
  logic        mr1, mw1, stall1, done1, mis1;
  logic [31:0] addr1, wd1, rdata1;

  int total = 0;
  int fails = 0;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut0 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr0), .MemWrite_i(mw0),
    .addr_i(addr0), .wdata_i(wd0), .rdata_o(rdata0), .stall_o(stall0),
    .done_o(done0), .misalign_o(mis0)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(mr1), .MemWrite_i(mw1),
    .addr_i(addr1), .wdata_i(wd1), .rdata_o(rdata1), .stall_o(stall1),
    .done_o(done1), .misalign_o(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request on dut0 from a negedge, holds it until DONE is seen,
  // then reports stall cycles, done pulses, DONE-cycle data and the state of
  // stall/done in the cycle after DONE.
  task automatic op0(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, output int stalls, output int dones,
                     output logic [31:0] rdat, output logic mis, output logic post);
    @(negedge clk);
    mr0 = rd; mw0 = wr; addr0 = a; wd0 = d;
    stalls = 0; dones = 0; rdat = '0; mis = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (stall0) stalls++;
      if (done0) begin
        dones++; rdat = rdata0; mis = mis0;
        mr0 = 1'b0; mw0 = 1'b0;
      end
      @(negedge clk);
      if (dones != 0) break;
    end
    #1;
    post = stall0 | done0;
  endtask

  int          st, dn;
  logic [31:0] rd;
  logic        ms, pst;
  logic [8:0]  stall_v, done_v;

  initial begin
    rst = 1'b1;
    mr0 = 0; mw0 = 0; addr0 = 0; wd0 = 0;
    mr1 = 0; mw1 = 0; addr1 = 0; wd1 = 0;
    #1;
    chk("reset rdata", rdata0, 32'h0);
    chk("reset stall", {31'b0, stall0}, 32'h0);
    chk("reset done",  {31'b0, done0}, 32'h0);
    chk("reset misalign", {31'b0, mis0}, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Write then read, LATENCY=3
    op0(0, 1, 32'h10, 32'hDEADBEEF, st, dn, rd, ms, pst);
    chk("wr stall cycles", st, 4);
    chk("wr done pulses", dn, 1);
    chk("wr idle after", {31'b0, pst}, 0);
    chk("wr rdata untouched", rd, 32'h0);
    op0(1, 0, 32'h10, 32'h0, st, dn, rd, ms, pst);
    chk("rd stall cycles", st, 4);
    chk("rd data", rd, 32'hDEADBEEF);
    chk("rd misalign", {31'b0, ms}, 0);
    chk("rd idle after", {31'b0, pst}, 0);

    // Wrap and write precedence
    op0(0, 1, 32'h400, 32'h11111111, st, dn, rd, ms, pst);
    op0(1, 0, 32'h0, 32'h0, st, dn, rd, ms, pst);
    chk("wrap to word0", rd, 32'h11111111);
    op0(1, 1, 32'h0, 32'h22222222, st, dn, rd, ms, pst);
    chk("rd+wr is write, rdata held", rd, 32'h11111111);
    chk("rd+wr done", dn, 1);
    op0(1, 0, 32'h0, 32'h0, st, dn, rd, ms, pst);
    chk("rd after rd+wr", rd, 32'h22222222);

    // Misaligned read
    op0(1, 0, 32'h13, 32'h0, st, dn, rd, ms, pst);
    chk("misaligned data", rd, 32'hDEADBEEF);
    chk("misaligned flag", {31'b0, ms}, 1);
    op0(1, 0, 32'h10, 32'h0, st, dn, rd, ms, pst);
    chk("aligned flag clear", {31'b0, ms}, 0);

    // Async reset in the DONE cycle of a misaligned read
    @(negedge clk);
    mr0 = 1; addr0 = 32'h13;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-reset done", {31'b0, done0}, 1);
    chk("pre-reset misalign", {31'b0, mis0}, 1);
    chk("pre-reset rdata", rdata0, 32'hDEADBEEF);
    rst = 1'b1; mr0 = 0;
    #1;
    chk("midcycle rst rdata", rdata0, 32'h0);
    chk("midcycle rst done", {31'b0, done0}, 0);
    chk("midcycle rst misalign", {31'b0, mis0}, 0);
    chk("midcycle rst stall", {31'b0, stall0}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset during ACCESS of a write must not commit it
    op0(0, 1, 32'h20, 32'h12345678, st, dn, rd, ms, pst);
    @(negedge clk);
    mw0 = 1; addr0 = 32'h20; wd0 = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("access stall", {31'b0, stall0}, 1);
    rst = 1'b1; mw0 = 0;
    #1;
    chk("rst in access stall", {31'b0, stall0}, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    op0(1, 0, 32'h20, 32'h0, st, dn, rd, ms, pst);
    chk("aborted write not committed", rd, 32'h12345678);

    // LATENCY=1 back-to-back: write, then reads held on EX/MEM
    stall_v = '0; done_v = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin mw1 = 1; addr1 = 32'h8; wd1 = 32'hA5A5A5A5; end
      if (c == 2) begin mw1 = 0; mr1 = 1; end
      #1;
      stall_v[c] = stall1;
      done_v[c]  = done1;
      if (c == 5 || c == 8) chk($sformatf("b2b rdata c%0d", c), rdata1, 32'hA5A5A5A5);
    end
    mr1 = 0;
    chk("b2b stall pattern", {23'b0, stall_v}, {23'b0, 9'b011011011});
    chk("b2b done pattern",  {23'b0, done_v},  {23'b0, 9'b100100100});
    @(negedge clk); #1;
    chk("b2b idle after", {30'b0, stall1, done1}, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
